// File: rtl/request_unit_if.sv
// Bundle of fetch/data-memory handshakes and control-unit decode/commit signals
// seen by the request unit; master is the request unit, slave is its environment.
interface request_unit_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic [31:0]      imemload;
    logic             MemRd;
    logic             MemWr;
    logic             Halt;
    logic [31:0]      Instr;
    logic             iREN;
    logic             dREN;
    logic             dWEN;
    logic             PCEn;
    logic             WrEn;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  ihit, dhit, imemload, MemRd, MemWr, Halt,
        output Instr, iREN, dREN, dWEN, PCEn, WrEn, halt, stall_cnt
    );

    modport slave (
        output ihit, dhit, imemload, MemRd, MemWr, Halt,
        input  Instr, iREN, dREN, dWEN, PCEn, WrEn, halt, stall_cnt
    );
endinterface

// File: rtl/request_unit.sv
// Fetch/data request sequencer feeding the control unit: holds the instruction
// register, issues memory requests and emits single-cycle PC/regfile commits.
module request_unit #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] INSTR_RST = 32'h00000000
) (
    input logic            CLK,
    input logic            nRST,
    request_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        DATA   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [31:0]      instr;
    logic [CNT_W-1:0] stall_cnt;
    logic             halted;
    logic             iren;
    logic             dren;
    logic             dwen;
    logic             commit;
    logic             stall_inc;
    logic             load_instr;

    // State, instruction register, sticky halt and stall counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            instr     <= INSTR_RST;
            stall_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            state <= next_state;
            if (load_instr) begin
                instr <= bus.imemload;
            end
            if (stall_inc) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (state == EXEC && bus.Halt) begin
                halted <= 1'b1;
            end
        end
    end

    // Next state and request outputs; commit in DATA is Mealy on dhit, and
    // a store beats a load when the decode illegally asserts both.
    always_comb begin
        next_state = state;
        iren       = 1'b0;
        dren       = 1'b0;
        dwen       = 1'b0;
        commit     = 1'b0;
        stall_inc  = 1'b0;
        load_instr = 1'b0;
        unique case (state)
            FETCH: begin
                iren = 1'b1;
                if (bus.ihit) begin
                    load_instr = 1'b1;
                    next_state = EXEC;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            EXEC: begin
                if (bus.Halt) begin
                    next_state = HALTED;
                end else if (bus.MemRd || bus.MemWr) begin
                    next_state = DATA;
                end else begin
                    commit     = 1'b1;
                    next_state = FETCH;
                end
            end
            DATA: begin
                dwen = bus.MemWr;
                dren = bus.MemRd && !bus.MemWr;
                if (bus.dhit) begin
                    commit     = 1'b1;
                    next_state = FETCH;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign bus.Instr     = instr;
    assign bus.iREN      = iren;
    assign bus.dREN      = dren;
    assign bus.dWEN      = dwen;
    assign bus.PCEn      = commit;
    assign bus.WrEn      = commit;
    assign bus.halt      = halted;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit with a 4-bit stall counter so wrap is reachable.
module tb_request_unit;

    localparam int          CW      = 4;
    localparam logic [31:0] ADD_W   = 32'h00221820;
    localparam logic [31:0] LOAD_W  = 32'h8C220004;
    localparam logic [31:0] STORE_W = 32'hAC220008;
    localparam logic [31:0] HALT_W  = 32'hFC000000;
    localparam logic [31:0] JUNK_W  = 32'hDEADBEEF;

    logic CLK;
    logic nRST;
    int   assertCount;
    int   failCount;
    logic [CW-1:0] expStall;

    request_unit_if #(.CNT_W(CW)) bus ();

    request_unit #(.CNT_W(CW), .INSTR_RST(32'h00000000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ih, input logic dh, input logic [31:0] word,
                                 input logic rd, input logic wr, input logic hl);
        bus.ihit     = ih;
        bus.dhit     = dh;
        bus.imemload = word;
        bus.MemRd    = rd;
        bus.MemWr    = wr;
        bus.Halt     = hl;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 0, 0);
        #3;
        assertCount++; if (bus.Instr !== 32'h0) begin failCount++; $display("[TB] FAIL reset_instr got=%h exp=%h", bus.Instr, 32'h0); end
        assertCount++; if (bus.stall_cnt !== 4'd0) begin failCount++; $display("[TB] FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
        assertCount++; if (bus.halt !== 1'b0) begin failCount++; $display("[TB] FAIL reset_halt got=%b exp=0", bus.halt); end
        assertCount++; if ({bus.iREN, bus.dREN, bus.dWEN, bus.PCEn, bus.WrEn} !== 5'b10000) begin failCount++; $display("[TB] FAIL reset_outs got=%b exp=10000", {bus.iREN, bus.dREN, bus.dWEN, bus.PCEn, bus.WrEn}); end
        @(negedge CLK);
        nRST = 1'b1;
        step();
        expStall = 4'd1;
    endtask

    task automatic test_add();
        // one miss cycle already elapsed after reset release; two more make three
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, JUNK_W, 0, 0, 0);
            assertCount++; if (bus.iREN !== 1'b1 || bus.PCEn !== 1'b0) begin failCount++; $display("[TB] FAIL add_wait iREN=%b PCEn=%b exp 1 0", bus.iREN, bus.PCEn); end
            step();
            expStall = expStall + 1'b1;
        end
        applyStimulus(1, 0, ADD_W, 0, 0, 0);
        step();
        applyStimulus(0, 0, JUNK_W, 0, 0, 0);
        assertCount++; if (bus.Instr !== ADD_W) begin failCount++; $display("[TB] FAIL add_instr got=%h exp=%h", bus.Instr, ADD_W); end
        assertCount++; if (bus.PCEn !== 1'b1 || bus.WrEn !== 1'b1 || bus.iREN !== 1'b0) begin failCount++; $display("[TB] FAIL add_commit PCEn=%b WrEn=%b iREN=%b exp 1 1 0", bus.PCEn, bus.WrEn, bus.iREN); end
        assertCount++; if (bus.stall_cnt !== 4'd3) begin failCount++; $display("[TB] FAIL add_stall got=%0d exp=3", bus.stall_cnt); end
        step();
        assertCount++; if (bus.PCEn !== 1'b0 || bus.WrEn !== 1'b0 || bus.iREN !== 1'b1) begin failCount++; $display("[TB] FAIL add_after PCEn=%b WrEn=%b iREN=%b exp 0 0 1", bus.PCEn, bus.WrEn, bus.iREN); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, ADD_W, 0, 0, 0);
            assertCount++; if (bus.PCEn !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_fetch_pcen got=%b exp=0", bus.PCEn); end
            step();
            applyStimulus(0, 0, JUNK_W, 0, 0, 0);
            assertCount++; if (bus.PCEn !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_exec_pcen got=%b exp=1", bus.PCEn); end
            step();
        end
        assertCount++; if (bus.stall_cnt !== expStall) begin failCount++; $display("[TB] FAIL b2b_stall got=%0d exp=%0d", bus.stall_cnt, expStall); end
    endtask

    task automatic test_load();
        applyStimulus(1, 0, LOAD_W, 0, 0, 0);
        step();
        applyStimulus(0, 0, JUNK_W, 1, 0, 0);
        assertCount++; if (bus.PCEn !== 1'b0 || bus.dREN !== 1'b0) begin failCount++; $display("[TB] FAIL load_exec PCEn=%b dREN=%b exp 0 0", bus.PCEn, bus.dREN); end
        step();
        // spurious ihit with a different word while waiting on data memory
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, JUNK_W, 1, 0, 0);
            assertCount++; if ({bus.dREN, bus.dWEN, bus.PCEn, bus.iREN} !== 4'b1000) begin failCount++; $display("[TB] FAIL load_wait%0d got=%b exp=1000", i, {bus.dREN, bus.dWEN, bus.PCEn, bus.iREN}); end
            step();
            expStall = expStall + 1'b1;
        end
        applyStimulus(0, 1, JUNK_W, 1, 0, 0);
        assertCount++; if ({bus.dREN, bus.PCEn, bus.WrEn} !== 3'b111) begin failCount++; $display("[TB] FAIL load_hit got=%b exp=111", {bus.dREN, bus.PCEn, bus.WrEn}); end
        assertCount++; if (bus.Instr !== LOAD_W) begin failCount++; $display("[TB] FAIL load_instr got=%h exp=%h", bus.Instr, LOAD_W); end
        assertCount++; if (bus.stall_cnt !== expStall) begin failCount++; $display("[TB] FAIL load_stall got=%0d exp=%0d", bus.stall_cnt, expStall); end
        step();
        applyStimulus(0, 0, JUNK_W, 0, 0, 0);
        assertCount++; if ({bus.iREN, bus.dREN, bus.PCEn} !== 3'b100) begin failCount++; $display("[TB] FAIL load_back got=%b exp=100", {bus.iREN, bus.dREN, bus.PCEn}); end
    endtask

    task automatic test_store();
        // spurious dhit while fetching
        applyStimulus(0, 1, JUNK_W, 0, 0, 0);
        assertCount++; if (bus.PCEn !== 1'b0 || bus.Instr !== LOAD_W) begin failCount++; $display("[TB] FAIL spur_fetch PCEn=%b Instr=%h exp 0 %h", bus.PCEn, bus.Instr, LOAD_W); end
        step();
        expStall = expStall + 1'b1;
        applyStimulus(1, 0, STORE_W, 0, 0, 0);
        step();
        applyStimulus(0, 0, JUNK_W, 0, 1, 0);
        step();
        applyStimulus(0, 1, JUNK_W, 0, 1, 0);
        assertCount++; if ({bus.dWEN, bus.dREN, bus.PCEn, bus.WrEn} !== 4'b1011) begin failCount++; $display("[TB] FAIL store_hit got=%b exp=1011", {bus.dWEN, bus.dREN, bus.PCEn, bus.WrEn}); end
        step();
        applyStimulus(0, 0, JUNK_W, 0, 0, 0);
        assertCount++; if (bus.dWEN !== 1'b0 || bus.stall_cnt !== expStall) begin failCount++; $display("[TB] FAIL store_after dWEN=%b stall=%0d exp 0 %0d", bus.dWEN, bus.stall_cnt, expStall); end
    endtask

    task automatic test_illegal();
        applyStimulus(1, 0, JUNK_W, 0, 0, 0);
        step();
        applyStimulus(0, 0, 32'h0, 1, 1, 0);
        step();
        applyStimulus(0, 1, 32'h0, 1, 1, 0);
        assertCount++; if ({bus.dWEN, bus.dREN, bus.PCEn} !== 3'b101) begin failCount++; $display("[TB] FAIL illegal got=%b exp=101", {bus.dWEN, bus.dREN, bus.PCEn}); end
        step();
    endtask

    task automatic test_halt();
        applyStimulus(1, 0, HALT_W, 0, 0, 0);
        step();
        applyStimulus(0, 0, JUNK_W, 0, 1, 1);
        assertCount++; if ({bus.PCEn, bus.dWEN, bus.halt} !== 3'b000) begin failCount++; $display("[TB] FAIL halt_exec got=%b exp=000", {bus.PCEn, bus.dWEN, bus.halt}); end
        step();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i % 2), 1'(i / 2), JUNK_W, 0, 1, 1);
            assertCount++; if ({bus.halt, bus.iREN, bus.dREN, bus.dWEN, bus.PCEn, bus.WrEn} !== 6'b100000) begin failCount++; $display("[TB] FAIL halted%0d got=%b exp=100000", i, {bus.halt, bus.iREN, bus.dREN, bus.dWEN, bus.PCEn, bus.WrEn}); end
            step();
        end
        assertCount++; if (bus.Instr !== HALT_W || bus.stall_cnt !== expStall) begin failCount++; $display("[TB] FAIL halted_frozen Instr=%h stall=%0d exp %h %0d", bus.Instr, bus.stall_cnt, HALT_W, expStall); end
    endtask

    task automatic test_async_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        applyStimulus(1, 0, LOAD_W, 0, 0, 0);
        step();
        applyStimulus(0, 0, JUNK_W, 1, 0, 0);
        step();
        assertCount++; if (bus.dREN !== 1'b1) begin failCount++; $display("[TB] FAIL areset_pre dREN=%b exp=1", bus.dREN); end
        #2;
        nRST = 1'b0;
        #1;
        assertCount++; if ({bus.dREN, bus.iREN} !== 2'b01) begin failCount++; $display("[TB] FAIL areset_drop dREN,iREN=%b exp=01", {bus.dREN, bus.iREN}); end
        assertCount++; if (bus.Instr !== 32'h0 || bus.stall_cnt !== 4'd0) begin failCount++; $display("[TB] FAIL areset_regs Instr=%h stall=%0d exp 0 0", bus.Instr, bus.stall_cnt); end
        applyStimulus(0, 0, JUNK_W, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        assertCount++; if (bus.iREN !== 1'b1 || bus.halt !== 1'b0) begin failCount++; $display("[TB] FAIL areset_release iREN=%b halt=%b exp 1 0", bus.iREN, bus.halt); end
    endtask

    task automatic test_wrap();
        // counter restarts from zero after the reset above; 17 misses wrap a 4-bit count to 1
        for (int i = 0; i < 17; i++) begin
            step();
        end
        assertCount++; if (bus.stall_cnt !== 4'd1) begin failCount++; $display("[TB] FAIL wrap got=%0d exp=1", bus.stall_cnt); end
        assertCount++; if (bus.iREN !== 1'b1 || bus.Instr !== 32'h0) begin failCount++; $display("[TB] FAIL wrap_state iREN=%b Instr=%h exp 1 0", bus.iREN, bus.Instr); end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        expStall    = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_load();
        test_store();
        test_illegal();
        test_halt();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
Fetch and memory-request sequencer that sits directly upstream of the control unit in the multicycle-memory datapath. It issues instruction reads, latches the returned word into the instruction register that drives the control unit's Instr input, and consumes the decoded MemRd/MemWr/Halt back from the control unit. It then sequences data-memory requests and produces single-cycle commit strobes for PC advance and register-file write. A sticky halt state and a stall-cycle counter complete the block.

Parameters:
CNT_W, 32, width of the stall-cycle counter
INSTR_RST, 32'h00000000, instruction register value after reset (decodes as sll $0,$0,0, a nop)

Ports:
CLK  input  1  system clock, rising-edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction memory returned imemload this cycle
dhit  input  1  data memory completed the current read/write this cycle
imemload  input  32  instruction word from instruction memory
MemRd  input  1  from control unit: current instruction is a load
MemWr  input  1  from control unit: current instruction is a store
Halt  input  1  from control unit: current instruction is halt
Instr  output  32  registered instruction word, drives control unit Instr
iREN  output  1  instruction read request
dREN  output  1  data read request
dWEN  output  1  data write request
PCEn  output  1  one-cycle commit: PC loads next-PC
WrEn  output  1  one-cycle commit: register file write permitted (equals PCEn)
halt  output  1  sticky halted flag to system
stall_cnt  output  CNT_W  cycles spent waiting on ihit or dhit

Behaviour:
- Reset (async, nRST=0): state=FETCH; Instr=INSTR_RST; stall_cnt=0; halt=0. Combinational outputs then follow FETCH: iREN=1, dREN=dWEN=PCEn=WrEn=0. Reset asserted mid-request drops dREN/dWEN immediately, without waiting for a clock edge.
- State machine: FETCH, EXEC, DATA, HALTED. Outputs are Moore except PCEn/WrEn in DATA, which are Mealy on dhit.
- FETCH: iREN=1.
  - ihit=0: stay; stall_cnt increments.
  - ihit=1: Instr<=imemload; go to EXEC.
  - dhit is ignored.
- EXEC: iREN=dREN=dWEN=0. Control-unit decode of the held Instr is valid this cycle.
  - Halt=1: go to HALTED; no PCEn. Halt has priority over MemRd/MemWr.
  - else MemRd|MemWr: go to DATA; no PCEn.
  - else: PCEn=WrEn=1 for this cycle; go to FETCH.
  - Latency for a non-memory instruction: ihit cycle, then the EXEC cycle, with commit in EXEC.
- DATA: dREN=MemRd, dWEN=MemWr. Both are held stable until dhit, because Instr is unchanged.
  - dhit=0: stay; stall_cnt increments.
  - dhit=1: PCEn=WrEn=1 in the same cycle; go to FETCH.
  - MemRd and MemWr both set (illegal decode): dWEN wins and dREN=0.
  - ihit is ignored.
- HALTED: absorbing until reset. halt=1 (registered, set on the EXEC->HALTED edge). All requests, PCEn and WrEn are 0. stall_cnt freezes.
- stall_cnt:
  - Increments by 1 per FETCH&!ihit or DATA&!dhit cycle.
  - Wraps modulo 2^CNT_W with no saturation.
  - Does not count EXEC cycles or hit cycles.
- Instr changes only on the FETCH&ihit edge or on reset; it is never updated in EXEC, DATA or HALTED.
- PCEn and WrEn are never high for two consecutive cycles. There is exactly one commit per non-halt instruction.
- iREN and (dREN|dWEN) are never asserted in the same cycle.

Test Plan:
- Reset, then hold ihit=0 for 3 cycles, then ihit=1 with imemload=32'h00221820 (add), MemRd=MemWr=Halt=0 -> Instr=32'h00221820 in EXEC; PCEn=WrEn=1 for exactly 1 cycle; stall_cnt=3; iREN reasserts the next cycle.
- Load (MemRd=1) with dhit delayed 4 cycles -> dREN=1, dWEN=0 held for 4 cycles; PCEn=1 only in the dhit cycle; stall_cnt increases by 4; back to FETCH.
- Store (MemWr=1) with dhit on the first DATA cycle -> dWEN high for 1 cycle; PCEn=1 in that same cycle; no stall_cnt increment.
- Halt=1 and MemWr=1 together in EXEC -> HALTED; halt=1 from the next cycle; dWEN never asserted; iREN=0 forever; later ihit/dhit pulses have no effect.
- Assert nRST=0 asynchronously mid-DATA with dREN=1 -> dREN drops before the next edge; Instr=0; stall_cnt=0; after release iREN=1.
- Spurious dhit during FETCH and ihit during DATA -> no state change, Instr unchanged, no PCEn; with CNT_W=4, 17 stall cycles yield stall_cnt=1 (wrap).
